// File: rtl/id_ex_stage_pkg.sv
// Shared encodings for the ID/EX operand-select stage.
//   FUNCT3_*    : RV32I ALU funct3 encodings (ADD/SUB and SRL/SRA share codes)
//   op1_sel_e   : operand-1 source select
//   ALU_CTRL_W  : width of {bit30 qualifier, funct3}
//   alu_ctrl_enc: builds alu_ctrl from the decoded fields
package id_ex_stage_pkg;

    localparam int ALU_CTRL_W = 4;

    localparam logic [2:0] FUNCT3_ADD  = 3'b000;
    localparam logic [2:0] FUNCT3_SUB  = 3'b000;
    localparam logic [2:0] FUNCT3_SLL  = 3'b001;
    localparam logic [2:0] FUNCT3_SLT  = 3'b010;
    localparam logic [2:0] FUNCT3_SLTU = 3'b011;
    localparam logic [2:0] FUNCT3_XOR  = 3'b100;
    localparam logic [2:0] FUNCT3_SRL  = 3'b101;
    localparam logic [2:0] FUNCT3_SRA  = 3'b101;
    localparam logic [2:0] FUNCT3_OR   = 3'b110;
    localparam logic [2:0] FUNCT3_AND  = 3'b111;

    typedef enum logic [1:0] {
        OP1_SEL_RS1  = 2'b00,
        OP1_SEL_PC   = 2'b01,
        OP1_SEL_ZERO = 2'b10,
        OP1_SEL_RSVD = 2'b11   // decodes as zero
    } op1_sel_e;

    // Bit 30 only matters for R-type SUB/SRA and for SRAI; for every other
    // I-type it is immediate data, so ADDI with bit30 set stays an ADD.
    function automatic logic [ALU_CTRL_W-1:0] alu_ctrl_enc(
        input logic       funct7b5,
        input logic       is_rtype,
        input logic [2:0] funct3
    );
        return {funct7b5 & (is_rtype | (funct3 == FUNCT3_SRA)), funct3};
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID -> EX issue bus: one decoded instruction plus the valid/ready handshake.
//   master (ID side) drives in_* and samples in_ready
//   slave  (ID/EX stage) samples in_* and drives in_ready
interface id_ex_stage_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    logic [REG_AW-1:0] in_rs1;
    logic [REG_AW-1:0] in_rs2;
    logic [REG_AW-1:0] in_rd;
    logic [XLEN-1:0]   in_rs1_val;
    logic [XLEN-1:0]   in_rs2_val;
    logic [XLEN-1:0]   in_imm;
    logic [2:0]        in_funct3;
    logic              in_funct7b5;
    logic              in_is_rtype;
    logic [1:0]        in_op1_sel;
    logic              in_use_imm;
    logic              in_is_load;
    logic              in_reg_we;

    modport master (
        output in_valid, in_pc, in_rs1, in_rs2, in_rd, in_rs1_val, in_rs2_val,
               in_imm, in_funct3, in_funct7b5, in_is_rtype, in_op1_sel,
               in_use_imm, in_is_load, in_reg_we,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_pc, in_rs1, in_rs2, in_rd, in_rs1_val, in_rs2_val,
               in_imm, in_funct3, in_funct7b5, in_is_rtype, in_op1_sel,
               in_use_imm, in_is_load, in_reg_we,
        output in_ready
    );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Single-source operand forwarding mux.
//   rs            : source register index
//   held          : value captured from the register file
//   mem_*, wb_*   : producer index / write enable / result per stage
//   fwd           : forwarded value (MEM beats WB; x0 never forwarded)
module fwd_mux #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [XLEN-1:0]   held,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_we,
    input  logic [XLEN-1:0]   mem_result,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_we,
    input  logic [XLEN-1:0]   wb_result,
    output logic [XLEN-1:0]   fwd
);

    always_comb begin
        fwd = held;
        if (rs != '0) begin
            if (mem_reg_we && (mem_rd == rs))     fwd = mem_result;
            else if (wb_reg_we && (wb_rd == rs))  fwd = wb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline slot and ALU operand select.
//   clk, rst_n          : clock, synchronous active-low reset
//   id (slave)          : decoded instruction + in_valid/in_ready handshake
//   flush               : kill held and incoming instruction
//   ex_ready            : EX/MEM consumes the held instruction
//   mem_*/wb_*          : forwarding sources
//   ex_valid .. ex_is_load : held slot, forwarded operands, alu_ctrl
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    id_ex_stage_if.slave          id,
    input  logic                  flush,
    input  logic                  ex_ready,
    input  logic [REG_AW-1:0]     mem_rd,
    input  logic                  mem_reg_we,
    input  logic [XLEN-1:0]       mem_result,
    input  logic [REG_AW-1:0]     wb_rd,
    input  logic                  wb_reg_we,
    input  logic [XLEN-1:0]       wb_result,
    output logic                  ex_valid,
    output logic [XLEN-1:0]       ex_pc,
    output logic [XLEN-1:0]       opr1,
    output logic [XLEN-1:0]       opr2,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic [XLEN-1:0]       ex_store_data,
    output logic [REG_AW-1:0]     ex_rd,
    output logic                  ex_reg_we,
    output logic                  ex_is_load
);

    typedef struct packed {
        logic                  valid;
        logic [XLEN-1:0]       pc;
        logic [REG_AW-1:0]     rs1;
        logic [REG_AW-1:0]     rs2;
        logic [REG_AW-1:0]     rd;
        logic [XLEN-1:0]       rs1_val;
        logic [XLEN-1:0]       rs2_val;
        logic [XLEN-1:0]       imm;
        logic [ALU_CTRL_W-1:0] alu_ctrl;
        op1_sel_e              op1_sel;
        logic                  use_imm;
        logic                  is_load;
        logic                  reg_we;
    } slot_t;

    slot_t           slot, slot_in;
    logic            load_use, capture;
    logic [XLEN-1:0] fwd_rs1, fwd_rs2;

    // Only a live load can stall; a bubble's stale rd/is_load never match.
    assign load_use = slot.valid & slot.is_load & (slot.rd != '0) &
                      ((slot.rd == id.in_rs1) | (slot.rd == id.in_rs2)) & id.in_valid;
    assign id.in_ready = (~slot.valid | ex_ready) & ~load_use & ~flush;
    assign capture     = id.in_valid & id.in_ready;

    always_comb begin
        slot_in          = '0;
        slot_in.valid    = 1'b1;
        slot_in.pc       = id.in_pc;
        slot_in.rs1      = id.in_rs1;
        slot_in.rs2      = id.in_rs2;
        slot_in.rd       = id.in_rd;
        slot_in.rs1_val  = id.in_rs1_val;
        slot_in.rs2_val  = id.in_rs2_val;
        slot_in.imm      = id.in_imm;
        slot_in.alu_ctrl = alu_ctrl_enc(id.in_funct7b5, id.in_is_rtype, id.in_funct3);
        slot_in.op1_sel  = op1_sel_e'(id.in_op1_sel);
        slot_in.use_imm  = id.in_use_imm;
        slot_in.is_load  = id.in_is_load;
        slot_in.reg_we   = id.in_reg_we;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (flush) begin
            slot.valid   <= 1'b0;
            slot.reg_we  <= 1'b0;
            slot.is_load <= 1'b0;
        end else if (capture) begin
            slot <= slot_in;
        end else if (ex_ready) begin
            slot.valid   <= 1'b0;
            slot.reg_we  <= 1'b0;
            slot.is_load <= 1'b0;
        end else if (slot.valid) begin
            // Stalled: absorb forwarded values so a producer leaving WB
            // during the stall is not lost.
            slot.rs1_val <= fwd_rs1;
            slot.rs2_val <= fwd_rs2;
        end
    end

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
        .rs(slot.rs1), .held(slot.rs1_val),
        .mem_rd(mem_rd), .mem_reg_we(mem_reg_we), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_we(wb_reg_we), .wb_result(wb_result),
        .fwd(fwd_rs1)
    );

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
        .rs(slot.rs2), .held(slot.rs2_val),
        .mem_rd(mem_rd), .mem_reg_we(mem_reg_we), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_we(wb_reg_we), .wb_result(wb_result),
        .fwd(fwd_rs2)
    );

    always_comb begin
        case (slot.op1_sel)
            OP1_SEL_RS1: opr1 = fwd_rs1;
            OP1_SEL_PC:  opr1 = slot.pc;
            default:     opr1 = '0;
        endcase
    end

    assign opr2          = slot.use_imm ? slot.imm : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign ex_valid      = slot.valid;
    assign ex_pc         = slot.pc;
    assign alu_ctrl      = slot.alu_ctrl;
    assign ex_rd         = slot.rd;
    assign ex_reg_we     = slot.reg_we;
    assign ex_is_load    = slot.is_load;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush, ex_ready;
    logic [REG_AW-1:0] mem_rd, wb_rd;
    logic              mem_reg_we, wb_reg_we;
    logic [XLEN-1:0]   mem_result, wb_result;
    logic              ex_valid, ex_reg_we, ex_is_load;
    logic [XLEN-1:0]   ex_pc, opr1, opr2, ex_store_data;
    logic [3:0]        alu_ctrl;
    logic [REG_AW-1:0] ex_rd;

    int checks = 0;
    int errors = 0;

    id_ex_stage_if #(.XLEN(XLEN), .REG_AW(REG_AW)) id_bus ();

    id_ex_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst_n(rst_n), .id(id_bus.slave),
        .flush(flush), .ex_ready(ex_ready),
        .mem_rd(mem_rd), .mem_reg_we(mem_reg_we), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_we(wb_reg_we), .wb_result(wb_result),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .opr1(opr1), .opr2(opr2),
        .alu_ctrl(alu_ctrl), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_we(ex_reg_we), .ex_is_load(ex_is_load)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(
        input logic [XLEN-1:0]   pc,
        input logic [REG_AW-1:0] rs1, rs2, rd,
        input logic [XLEN-1:0]   v1, v2, imm,
        input logic [2:0]        f3,
        input logic              b5, rtype,
        input logic [1:0]        sel,
        input logic              use_imm, is_load, we
    );
        id_bus.in_pc = pc;       id_bus.in_rs1 = rs1;   id_bus.in_rs2 = rs2;
        id_bus.in_rd = rd;       id_bus.in_rs1_val = v1; id_bus.in_rs2_val = v2;
        id_bus.in_imm = imm;     id_bus.in_funct3 = f3; id_bus.in_funct7b5 = b5;
        id_bus.in_is_rtype = rtype; id_bus.in_op1_sel = sel;
        id_bus.in_use_imm = use_imm; id_bus.in_is_load = is_load;
        id_bus.in_reg_we = we;
    endtask

    task automatic clear_fwd();
        mem_rd = '0; mem_reg_we = 1'b0; mem_result = '0;
        wb_rd  = '0; wb_reg_we  = 1'b0; wb_result  = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", ex_valid); end
        checks++; if (alu_ctrl !== 4'h0) begin errors++; $display("FAIL reset_alu_ctrl got %0h exp 0", alu_ctrl); end
        checks++; if (ex_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got %0d exp 0", ex_rd); end
        checks++; if (ex_reg_we !== 1'b0 || ex_is_load !== 1'b0) begin errors++; $display("FAIL reset_we_load got %0b%0b exp 00", ex_reg_we, ex_is_load); end
        checks++; if (opr1 !== 32'h0) begin errors++; $display("FAIL reset_opr1 got %0h exp 0", opr1); end
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        // ADD x3,x1,x2
        set_instr(32'h40, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 3'b000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        id_bus.in_valid = 1'b1; ex_ready = 1'b1;
        #1;
        checks++; if (id_bus.in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready got %0b exp 1", id_bus.in_ready); end
        tick();
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %0b exp 1", ex_valid); end
        checks++; if (opr1 !== 32'd5 || opr2 !== 32'd7) begin errors++; $display("FAIL add_oprs got %0h/%0h exp 5/7", opr1, opr2); end
        checks++; if (alu_ctrl !== 4'b0000 || ex_rd !== 5'd3 || ex_pc !== 32'h40) begin errors++; $display("FAIL add_fields got ctrl=%0h rd=%0d pc=%0h exp 0/3/40", alu_ctrl, ex_rd, ex_pc); end
        // XOR x4,x3,x2 captured immediately behind it
        set_instr(32'h44, 5'd3, 5'd2, 5'd4, 32'h0F, 32'hF0, 32'd0, 3'b100, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        tick();
        checks++; if (opr1 !== 32'h0F || ex_store_data !== 32'hF0 || ex_rd !== 5'd4) begin errors++; $display("FAIL b2b_xor got opr1=%0h sd=%0h rd=%0d exp f/f0/4", opr1, ex_store_data, ex_rd); end
        checks++; if (alu_ctrl !== 4'b0100) begin errors++; $display("FAIL b2b_ctrl got %0h exp 4", alu_ctrl); end
        id_bus.in_valid = 1'b0;
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_reg_we !== 1'b0) begin errors++; $display("FAIL drain_bubble got v=%0b we=%0b exp 0/0", ex_valid, ex_reg_we); end
    endtask

    task automatic test_forwarding();
        // SUB x3,x1,x2
        set_instr(32'h80, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0, 3'b000, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        id_bus.in_valid = 1'b1; ex_ready = 1'b1;
        tick();
        id_bus.in_valid = 1'b0;
        mem_rd = 5'd1; mem_reg_we = 1'b1; mem_result = 32'h10;
        wb_rd  = 5'd1; wb_reg_we  = 1'b1; wb_result  = 32'h20;
        #1;
        checks++; if (opr1 !== 32'h10) begin errors++; $display("FAIL fwd_mem_prio got %0h exp 10", opr1); end
        checks++; if (alu_ctrl !== 4'b1000) begin errors++; $display("FAIL sub_ctrl got %0h exp 8", alu_ctrl); end
        mem_reg_we = 1'b0;
        #1;
        checks++; if (opr1 !== 32'h20) begin errors++; $display("FAIL fwd_wb got %0h exp 20", opr1); end
        mem_rd = 5'd2; mem_reg_we = 1'b1;
        #1;
        checks++; if (opr2 !== 32'h10 || ex_store_data !== 32'h10) begin errors++; $display("FAIL fwd_rs2_mem got %0h/%0h exp 10/10", opr2, ex_store_data); end
        // SUB x3,x0,x0 with forwarders targeting x0
        clear_fwd();
        set_instr(32'h84, 5'd0, 5'd0, 5'd3, 32'h55, 32'h66, 32'd0, 3'b000, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        id_bus.in_valid = 1'b1;
        tick();
        id_bus.in_valid = 1'b0;
        mem_rd = 5'd0; mem_reg_we = 1'b1; mem_result = 32'h10;
        wb_rd  = 5'd0; wb_reg_we  = 1'b1; wb_result  = 32'h20;
        #1;
        checks++; if (opr1 !== 32'h55 || opr2 !== 32'h66) begin errors++; $display("FAIL fwd_x0 got %0h/%0h exp 55/66", opr1, opr2); end
        clear_fwd();
        tick();
    endtask

    task automatic test_load_use();
        // LW x5,4(x1)
        set_instr(32'h100, 5'd1, 5'd0, 5'd5, 32'h1000, 32'd0, 32'd4, 3'b010, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1);
        id_bus.in_valid = 1'b1; ex_ready = 1'b1;
        tick();
        checks++; if (ex_is_load !== 1'b1 || opr2 !== 32'd4 || opr1 !== 32'h1000) begin errors++; $display("FAIL lw_capture got ld=%0b opr1=%0h opr2=%0h exp 1/1000/4", ex_is_load, opr1, opr2); end
        // ADD x6,x5,x0 depends on the load
        set_instr(32'h104, 5'd5, 5'd0, 5'd6, 32'd0, 32'd0, 32'd0, 3'b000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        #1;
        checks++; if (id_bus.in_ready !== 1'b0) begin errors++; $display("FAIL load_use_stall got %0b exp 0", id_bus.in_ready); end
        tick();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL load_use_bubble got %0b exp 0", ex_valid); end
        wb_rd = 5'd5; wb_reg_we = 1'b1; wb_result = 32'hABCD;
        #1;
        checks++; if (id_bus.in_ready !== 1'b1) begin errors++; $display("FAIL bubble_no_stall got %0b exp 1", id_bus.in_ready); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || opr1 !== 32'hABCD) begin errors++; $display("FAIL load_use_fwd got v=%0b rd=%0d opr1=%0h exp 1/6/abcd", ex_valid, ex_rd, opr1); end
        id_bus.in_valid = 1'b0;
        clear_fwd();
        tick();
    endtask

    task automatic test_stall_refresh();
        // ADD x7,x1,x4
        set_instr(32'h140, 5'd1, 5'd4, 5'd7, 32'd1, 32'd3, 32'd0, 3'b000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        id_bus.in_valid = 1'b1; ex_ready = 1'b1;
        tick();
        id_bus.in_valid = 1'b0; ex_ready = 1'b0;
        wb_rd = 5'd4; wb_reg_we = 1'b1; wb_result = 32'd9;
        #1;
        checks++; if (opr2 !== 32'd9) begin errors++; $display("FAIL refresh_c1 got %0d exp 9", opr2); end
        tick();
        wb_reg_we = 1'b0;
        #1;
        checks++; if (opr2 !== 32'd9 || ex_valid !== 1'b1) begin errors++; $display("FAIL refresh_c2 got %0d v=%0b exp 9/1", opr2, ex_valid); end
        tick();
        checks++; if (opr2 !== 32'd9) begin errors++; $display("FAIL refresh_c3 got %0d exp 9", opr2); end
        clear_fwd();
    endtask

    task automatic test_flush();
        // Still holding ADD x7 with ex_ready low; new instruction arrives with flush.
        set_instr(32'h200, 5'd1, 5'd2, 5'd9, 32'd1, 32'd2, 32'd0, 3'b000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        id_bus.in_valid = 1'b1; flush = 1'b1;
        #1;
        checks++; if (id_bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %0b exp 0", id_bus.in_ready); end
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_reg_we !== 1'b0) begin errors++; $display("FAIL flush_kill got v=%0b we=%0b exp 0/0", ex_valid, ex_reg_we); end
        flush = 1'b0; id_bus.in_valid = 1'b0; ex_ready = 1'b1;
        tick();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_after got %0b exp 0", ex_valid); end
    endtask

    task automatic test_op1_sel();
        // LUI-form ADDI with bit30 set
        set_instr(32'h300, 5'd0, 5'd0, 5'd1, 32'h77, 32'd0, 32'h12345000, 3'b000, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b1);
        id_bus.in_valid = 1'b1; ex_ready = 1'b1;
        tick();
        checks++; if (alu_ctrl !== 4'b0000) begin errors++; $display("FAIL addi_b30_ctrl got %0h exp 0", alu_ctrl); end
        checks++; if (opr1 !== 32'h0 || opr2 !== 32'h12345000) begin errors++; $display("FAIL lui_oprs got %0h/%0h exp 0/12345000", opr1, opr2); end
        // SRAI x2,x1,3
        set_instr(32'h304, 5'd1, 5'd0, 5'd2, 32'h80, 32'd0, 32'd3, 3'b101, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
        tick();
        checks++; if (alu_ctrl !== 4'b1101 || opr1 !== 32'h80) begin errors++; $display("FAIL srai got ctrl=%0h opr1=%0h exp d/80", alu_ctrl, opr1); end
        // AUIPC
        set_instr(32'h308, 5'd0, 5'd0, 5'd3, 32'd0, 32'd0, 32'h1000, 3'b000, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1);
        tick();
        checks++; if (opr1 !== 32'h308) begin errors++; $display("FAIL auipc_pc got %0h exp 308", opr1); end
        // Reserved op1_sel reads as zero
        set_instr(32'h30C, 5'd1, 5'd0, 5'd3, 32'h55, 32'd0, 32'd1, 3'b000, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b1);
        tick();
        checks++; if (opr1 !== 32'h0) begin errors++; $display("FAIL rsvd_sel got %0h exp 0", opr1); end
        id_bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_stall();
        set_instr(32'h400, 5'd1, 5'd2, 5'd8, 32'd1, 32'd2, 32'd0, 3'b000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        id_bus.in_valid = 1'b1; ex_ready = 1'b1;
        tick();
        id_bus.in_valid = 1'b0; ex_ready = 1'b0;
        tick();
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL stall_hold got %0b exp 1", ex_valid); end
        rst_n = 1'b0;
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_reg_we !== 1'b0 || ex_rd !== 5'd0) begin errors++; $display("FAIL reset_mid_stall got v=%0b we=%0b rd=%0d exp 0/0/0", ex_valid, ex_reg_we, ex_rd); end
        rst_n = 1'b1;
        tick();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL post_reset got %0b exp 0", ex_valid); end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b0;
        id_bus.in_valid = 1'b0;
        set_instr('0, '0, '0, '0, '0, '0, '0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        clear_fwd();
        test_reset();
        test_back_to_back();
        test_forwarding();
        test_load_use();
        test_stall_refresh();
        test_flush();
        test_op1_sel();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
